reservation_station: RTL and testbench

- Unified reservation station directly downstream of the rename stage in the front end.
- Rename writes fully-formed entries into a slot it picks from this block's free-slot output.
- Entries with not-ready sources capture operands from the common data bus (CDB).
- Ready entries are selected and issued one per cycle to execution over a valid/ready handshake.

---
 rtl/reservation_station.sv | 260 ++++++++++++++++++++++++++
 tb/tb_reservation_station.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
//==============================================================================
// Module      : reservation_station
// Description : Unified reservation station fed by rename. Entries capture
//               missing operands from the CDB, and one ready entry per cycle
//               moves into a single-entry issue register (valid/ready).
//               Optional build macro RES_ST_OLDEST_FIRST_EN selects the oldest
//               eligible entry through an age matrix instead of lowest index.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reservation_station #(
   parameter int  RS_DEPTH      = 8,
   parameter int  PAYLOAD_WIDTH = 32,
   parameter int  TAG_WIDTH     = 6,
   parameter int  DATA_WIDTH    = 32,
   localparam int AW            = $clog2(RS_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [PAYLOAD_WIDTH-1:0] wr_payload,
   input  logic [TAG_WIDTH-1:0]     wr_prd,
   input  logic [TAG_WIDTH-1:0]     wr_rs1_tag,
   input  logic [TAG_WIDTH-1:0]     wr_rs2_tag,
   input  logic                     wr_rs1_rdy,
   input  logic                     wr_rs2_rdy,
   input  logic [DATA_WIDTH-1:0]    wr_rs1_val,
   input  logic [DATA_WIDTH-1:0]    wr_rs2_val,
   output logic                     free_valid,
   output logic [AW-1:0]            free_addr,
   output logic                     full,
   output logic [AW:0]              count,
   input  logic                     cdb_valid,
   input  logic [TAG_WIDTH-1:0]     cdb_tag,
   input  logic [DATA_WIDTH-1:0]    cdb_data,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [PAYLOAD_WIDTH-1:0] issue_payload,
   output logic [TAG_WIDTH-1:0]     issue_prd,
   output logic [DATA_WIDTH-1:0]    issue_rs1_val,
   output logic [DATA_WIDTH-1:0]    issue_rs2_val
);

   // Entry storage
   logic [RS_DEPTH-1:0]      valid_q, valid_d;
   logic [RS_DEPTH-1:0]      rdy1_q, rdy1_d;
   logic [RS_DEPTH-1:0]      rdy2_q, rdy2_d;
   logic [PAYLOAD_WIDTH-1:0] payload_q [RS_DEPTH];
   logic [PAYLOAD_WIDTH-1:0] payload_d [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     prd_q [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     prd_d [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     tag1_q [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     tag1_d [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     tag2_q [RS_DEPTH];
   logic [TAG_WIDTH-1:0]     tag2_d [RS_DEPTH];
   logic [DATA_WIDTH-1:0]    val1_q [RS_DEPTH];
   logic [DATA_WIDTH-1:0]    val1_d [RS_DEPTH];
   logic [DATA_WIDTH-1:0]    val2_q [RS_DEPTH];
   logic [DATA_WIDTH-1:0]    val2_d [RS_DEPTH];

   // Issue register and occupancy
   logic                     issue_valid_q, issue_valid_d;
   logic [PAYLOAD_WIDTH-1:0] issue_payload_q, issue_payload_d;
   logic [TAG_WIDTH-1:0]     issue_prd_q, issue_prd_d;
   logic [DATA_WIDTH-1:0]    issue_rs1_val_q, issue_rs1_val_d;
   logic [DATA_WIDTH-1:0]    issue_rs2_val_q, issue_rs2_val_d;
   logic [AW:0]              count_q, count_d;

   // Control
   logic [RS_DEPTH-1:0]      elig;
   logic                     any_elig;
   logic [AW-1:0]            sel;
   logic                     issue_fire;
   logic                     wr_accept;
   logic                     byp1, byp2;
   logic                     free_found;

`ifdef RES_ST_OLDEST_FIRST_EN
   // age_q[i][j] = 1 means entry i is older than entry j
   logic [RS_DEPTH-1:0]      age_q [RS_DEPTH];
   logic [RS_DEPTH-1:0]      age_d [RS_DEPTH];
   logic                     older;
`endif

   assign elig       = valid_q & rdy1_q & rdy2_q;
   assign any_elig   = |elig;
   assign issue_fire = any_elig && (!issue_valid_q || issue_ready);
   assign wr_accept  = wr_en && !flush && !full && !valid_q[wr_addr];
   assign byp1       = cdb_valid && !wr_rs1_rdy && (cdb_tag == wr_rs1_tag);
   assign byp2       = cdb_valid && !wr_rs2_rdy && (cdb_tag == wr_rs2_tag);

   // Lowest-index free slot, derived only from registered valid bits
   always_comb begin
      free_addr  = '0;
      free_found = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_addr  = AW'(i);
            free_found = 1'b1;
         end
      end
      free_valid = ~&valid_q;
      full       = &valid_q;
   end

`ifdef RES_ST_OLDEST_FIRST_EN
   // Pick the eligible entry that is older than every other eligible entry
   always_comb begin
      sel   = '0;
      older = 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) begin
         older = elig[i];
         for (int j = 0; j < RS_DEPTH; j++) begin
            if (j != i && elig[j] && !age_q[i][j]) older = 1'b0;
         end
         if (older) sel = AW'(i);
      end
   end

   // New entry becomes younger than every entry valid at the write edge
   always_comb begin
      age_d = age_q;
      if (wr_accept) begin
         for (int j = 0; j < RS_DEPTH; j++) begin
            age_d[wr_addr][j] = 1'b0;
            age_d[j][wr_addr] = valid_q[j];
         end
      end
   end

   // Age matrix register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
      end else begin
         age_q <= age_d;
      end
   end
`else
   // Pick the lowest-index eligible entry
   always_comb begin
      sel = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (elig[i]) sel = AW'(i);
      end
   end
`endif

   // Entry next state: CDB wakeup, issue dequeue, rename write, flush
   always_comb begin
      valid_d   = valid_q;
      rdy1_d    = rdy1_q;
      rdy2_d    = rdy2_q;
      payload_d = payload_q;
      prd_d     = prd_q;
      tag1_d    = tag1_q;
      tag2_d    = tag2_q;
      val1_d    = val1_q;
      val2_d    = val2_q;
      for (int i = 0; i < RS_DEPTH; i++) begin
         if (valid_q[i] && cdb_valid) begin
            if (!rdy1_q[i] && (tag1_q[i] == cdb_tag)) begin
               rdy1_d[i] = 1'b1;
               val1_d[i] = cdb_data;
            end
            if (!rdy2_q[i] && (tag2_q[i] == cdb_tag)) begin
               rdy2_d[i] = 1'b1;
               val2_d[i] = cdb_data;
            end
         end
      end
      if (issue_fire) valid_d[sel] = 1'b0;
      if (wr_accept) begin
         valid_d[wr_addr]   = 1'b1;
         payload_d[wr_addr] = wr_payload;
         prd_d[wr_addr]     = wr_prd;
         tag1_d[wr_addr]    = wr_rs1_tag;
         tag2_d[wr_addr]    = wr_rs2_tag;
         rdy1_d[wr_addr]    = wr_rs1_rdy | byp1;
         rdy2_d[wr_addr]    = wr_rs2_rdy | byp2;
         val1_d[wr_addr]    = byp1 ? cdb_data : wr_rs1_val;
         val2_d[wr_addr]    = byp2 ? cdb_data : wr_rs2_val;
      end
      if (flush) valid_d = '0;
   end

   // Issue register and occupancy next state
   always_comb begin
      issue_valid_d   = issue_valid_q;
      issue_payload_d = issue_payload_q;
      issue_prd_d     = issue_prd_q;
      issue_rs1_val_d = issue_rs1_val_q;
      issue_rs2_val_d = issue_rs2_val_q;
      count_d         = count_q + {{AW{1'b0}}, wr_accept} - {{AW{1'b0}}, issue_fire};
      if (flush) begin
         issue_valid_d = 1'b0;
         count_d       = '0;
      end else if (issue_fire) begin
         issue_valid_d   = 1'b1;
         issue_payload_d = payload_q[sel];
         issue_prd_d     = prd_q[sel];
         issue_rs1_val_d = val1_q[sel];
         issue_rs2_val_d = val2_q[sel];
      end else if (issue_ready) begin
         issue_valid_d = 1'b0;
      end
   end

   // Control and issue registers with reset
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q         <= '0;
         count_q         <= '0;
         issue_valid_q   <= 1'b0;
         issue_payload_q <= '0;
         issue_prd_q     <= '0;
         issue_rs1_val_q <= '0;
         issue_rs2_val_q <= '0;
      end else begin
         valid_q         <= valid_d;
         count_q         <= count_d;
         issue_valid_q   <= issue_valid_d;
         issue_payload_q <= issue_payload_d;
         issue_prd_q     <= issue_prd_d;
         issue_rs1_val_q <= issue_rs1_val_d;
         issue_rs2_val_q <= issue_rs2_val_d;
      end
   end

   // Entry payload storage; qualified by valid bits, so no reset needed
   always_ff @(posedge clk) begin
      rdy1_q    <= rdy1_d;
      rdy2_q    <= rdy2_d;
      payload_q <= payload_d;
      prd_q     <= prd_d;
      tag1_q    <= tag1_d;
      tag2_q    <= tag2_d;
      val1_q    <= val1_d;
      val2_q    <= val2_d;
   end

   assign count         = count_q;
   assign issue_valid   = issue_valid_q;
   assign issue_payload = issue_payload_q;
   assign issue_prd     = issue_prd_q;
   assign issue_rs1_val = issue_rs1_val_q;
   assign issue_rs2_val = issue_rs2_val_q;

`ifndef SYNTHESIS
   // Rename must never target an occupied slot while free slots remain
   a_no_overwrite: assert property (@(posedge clk) disable iff (rst)
      !(wr_en && !flush && !full && valid_q[wr_addr]));
`endif

endmodule

`default_nettype wire

// File: tb/tb_reservation_station.sv
//==============================================================================
// Module      : tb_reservation_station
// Description : Self-checking bench for reservation_station: directed vector
//               table, hand-written corner sequences and a randomized run
//               against an entry-list reference model with sequence numbers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_reservation_station;

   logic        clk = 1'b0;
   logic        rst, flush, wr_en;
   logic [2:0]  wr_addr;
   logic [31:0] wr_payload;
   logic [5:0]  wr_prd, wr_rs1_tag, wr_rs2_tag;
   logic        wr_rs1_rdy, wr_rs2_rdy;
   logic [31:0] wr_rs1_val, wr_rs2_val;
   logic        free_valid, full;
   logic [2:0]  free_addr;
   logic [3:0]  count;
   logic        cdb_valid;
   logic [5:0]  cdb_tag;
   logic [31:0] cdb_data;
   logic        issue_valid, issue_ready;
   logic [31:0] issue_payload, issue_rs1_val, issue_rs2_val;
   logic [5:0]  issue_prd;

   reservation_station dut (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_payload(wr_payload), .wr_prd(wr_prd), .wr_rs1_tag(wr_rs1_tag),
      .wr_rs2_tag(wr_rs2_tag), .wr_rs1_rdy(wr_rs1_rdy), .wr_rs2_rdy(wr_rs2_rdy),
      .wr_rs1_val(wr_rs1_val), .wr_rs2_val(wr_rs2_val), .free_valid(free_valid),
      .free_addr(free_addr), .full(full), .count(count), .cdb_valid(cdb_valid),
      .cdb_tag(cdb_tag), .cdb_data(cdb_data), .issue_valid(issue_valid),
      .issue_ready(issue_ready), .issue_payload(issue_payload), .issue_prd(issue_prd),
      .issue_rs1_val(issue_rs1_val), .issue_rs2_val(issue_rs2_val)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: list of entries, age kept as an arrival sequence number
   typedef struct {
      bit          v;
      logic [31:0] pl;
      logic [5:0]  prd, t1, t2;
      bit          r1, r2;
      logic [31:0] d1, d2;
      int unsigned seq;
   } ment_t;

   ment_t       m [8];
   bit          m_iv;
   logic [31:0] m_ipl, m_iv1, m_iv2;
   logic [5:0]  m_iprd;
   int unsigned m_seq;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < 8; i++) if (m[i].v) c++;
      return c;
   endfunction

   function automatic int m_free();
      for (int i = 0; i < 8; i++) if (!m[i].v) return i;
      return 0;
   endfunction

   task automatic model_step();
      int pick;
      bit fire, wok;
      if (rst) begin
         for (int i = 0; i < 8; i++) m[i].v = 0;
         m_iv = 0; m_ipl = 0; m_iprd = 0; m_iv1 = 0; m_iv2 = 0;
         return;
      end
      if (flush) begin
         for (int i = 0; i < 8; i++) m[i].v = 0;
         m_iv = 0;
         return;
      end
      pick = -1;
      for (int i = 0; i < 8; i++) begin
         if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RES_ST_OLDEST_FIRST_EN
            if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
            if (pick < 0) pick = i;
`endif
         end
      end
      fire = (pick >= 0) && (!m_iv || issue_ready);
      wok  = wr_en && !m[wr_addr].v;
      if (fire) begin
         m_iv = 1; m_ipl = m[pick].pl; m_iprd = m[pick].prd;
         m_iv1 = m[pick].d1; m_iv2 = m[pick].d2;
         m[pick].v = 0;
      end else if (issue_ready) begin
         m_iv = 0;
      end
      for (int i = 0; i < 8; i++) begin
         if (m[i].v && cdb_valid) begin
            if (!m[i].r1 && m[i].t1 == cdb_tag) begin m[i].r1 = 1; m[i].d1 = cdb_data; end
            if (!m[i].r2 && m[i].t2 == cdb_tag) begin m[i].r2 = 1; m[i].d2 = cdb_data; end
         end
      end
      if (wok) begin
         m[wr_addr].v   = 1;
         m[wr_addr].pl  = wr_payload;
         m[wr_addr].prd = wr_prd;
         m[wr_addr].t1  = wr_rs1_tag;
         m[wr_addr].t2  = wr_rs2_tag;
         m[wr_addr].r1  = wr_rs1_rdy || (cdb_valid && cdb_tag == wr_rs1_tag);
         m[wr_addr].r2  = wr_rs2_rdy || (cdb_valid && cdb_tag == wr_rs2_tag);
         m[wr_addr].d1  = wr_rs1_rdy ? wr_rs1_val : (cdb_valid && cdb_tag == wr_rs1_tag) ? cdb_data : wr_rs1_val;
         m[wr_addr].d2  = wr_rs2_rdy ? wr_rs2_val : (cdb_valid && cdb_tag == wr_rs2_tag) ? cdb_data : wr_rs2_val;
         m[wr_addr].seq = m_seq;
         m_seq++;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("issue_valid", issue_valid, m_iv);
      chk("count", count, m_count());
      chk("full", full, m_count() == 8);
      chk("free_valid", free_valid, m_count() != 8);
      if (m_count() != 8) chk("free_addr", free_addr, m_free());
      if (m_iv) begin
         chk("issue_payload", issue_payload, m_ipl);
         chk("issue_prd", issue_prd, m_iprd);
         chk("issue_rs1_val", issue_rs1_val, m_iv1);
         chk("issue_rs2_val", issue_rs2_val, m_iv2);
      end
   endtask

   // One clock: model advances on the current inputs, DUT sampled at negedge
   task automatic cycle();
      model_step();
      @(posedge clk);
      @(negedge clk);
      compare_model();
   endtask

   task automatic idle();
      wr_en = 0; cdb_valid = 0; flush = 0; rst = 0;
   endtask

   task automatic set_wr(input int a, input int prd, input int t1, input bit r1,
                         input logic [31:0] v1, input int t2, input bit r2,
                         input logic [31:0] v2, input logic [31:0] pl);
      wr_en = 1; wr_addr = 3'(a); wr_prd = 6'(prd);
      wr_rs1_tag = 6'(t1); wr_rs1_rdy = r1; wr_rs1_val = v1;
      wr_rs2_tag = 6'(t2); wr_rs2_rdy = r2; wr_rs2_val = v2;
      wr_payload = pl;
   endtask

   task automatic do_reset();
      idle(); rst = 1;
      cycle();
      rst = 0;
   endtask

   typedef struct {
      bit          we;
      int          addr, prd, t1;
      bit          r1;
      logic [31:0] v1;
      int          t2;
      bit          r2;
      logic [31:0] v2, pl;
      bit          cv;
      int          ct;
      logic [31:0] cd;
      bit          e_iv;
      int          e_cnt, e_free, e_prd;
      logic [31:0] e_pl, e_v1, e_v2;
   } vec_t;

   vec_t vt [7];

   initial begin
      int n_iss;
      bit got;
      int flist [$];
      idle();
      issue_ready = 1;
      wr_addr = 0; wr_payload = 0; wr_prd = 0; wr_rs1_tag = 0; wr_rs2_tag = 0;
      wr_rs1_rdy = 0; wr_rs2_rdy = 0; wr_rs1_val = 0; wr_rs2_val = 0;
      cdb_tag = 0; cdb_data = 0;
      m_seq = 0;

      //               we a prd t1 r1 v1     t2 r2 v2     pl       cv ct cd    iv cnt fr prd pl       v1     v2
      vt[0] = '{1, 0, 7, 0, 1, 32'h11, 0, 1, 32'h22, 32'hA5A5, 0, 0, 0,     0, 1, 1, 0, 0,       0,     0};
      vt[1] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,      0,        0, 0, 0,     1, 0, 0, 7, 32'hA5A5, 32'h11, 32'h22};
      vt[2] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,      0,        0, 0, 0,     0, 0, 0, 0, 0,       0,     0};
      vt[3] = '{1, 0, 9, 3, 0, 0,      0, 1, 32'h44, 32'h5A5A, 0, 0, 0,     0, 1, 1, 0, 0,       0,     0};
      vt[4] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,      0,        1, 3, 32'h33, 0, 1, 1, 0, 0,      0,     0};
      vt[5] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,      0,        0, 0, 0,     1, 0, 0, 9, 32'h5A5A, 32'h33, 32'h44};
      vt[6] = '{0, 0, 0, 0, 0, 0,      0, 0, 0,      0,        0, 0, 0,     0, 0, 0, 0, 0,       0,     0};

      // Reset state
      do_reset();
      chk("rst_iv", issue_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_free_valid", free_valid, 1);
      chk("rst_free_addr", free_addr, 0);
      chk("rst_full", full, 0);
      chk("rst_payload", issue_payload, 0);
      chk("rst_rs1", issue_rs1_val, 0);

      // Table-driven: single write/issue latency and a CDB wakeup
      for (int k = 0; k < 7; k++) begin
         idle();
         if (vt[k].we) set_wr(vt[k].addr, vt[k].prd, vt[k].t1, vt[k].r1, vt[k].v1,
                              vt[k].t2, vt[k].r2, vt[k].v2, vt[k].pl);
         cdb_valid = vt[k].cv; cdb_tag = 6'(vt[k].ct); cdb_data = vt[k].cd;
         cycle();
         chk("tbl_iv", issue_valid, vt[k].e_iv);
         chk("tbl_count", count, vt[k].e_cnt);
         chk("tbl_free", free_addr, vt[k].e_free);
         if (vt[k].e_iv) begin
            chk("tbl_prd", issue_prd, vt[k].e_prd);
            chk("tbl_pl", issue_payload, vt[k].e_pl);
            chk("tbl_v1", issue_rs1_val, vt[k].e_v1);
            chk("tbl_v2", issue_rs2_val, vt[k].e_v2);
         end
      end

      // Fill all slots waiting on tag 5, one broadcast wakes all of them
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_wr(i, 16 + i, 5, 0, 0, 0, 1, i, i);
         cycle();
      end
      idle();
      chk("fill_full", full, 1);
      chk("fill_free_valid", free_valid, 0);
      set_wr(3, 1, 1, 1, 1, 1, 1, 1, 32'hBAD);
      cycle();
      chk("ninth_count", count, 8);
      idle(); cdb_valid = 1; cdb_tag = 5; cdb_data = 32'hDEADBEEF;
      cycle();
      idle();
      n_iss = 0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         chk("drain_iv", issue_valid, k < 8);
         if (issue_valid) begin
            n_iss++;
            chk("drain_rs1", issue_rs1_val, 32'hDEADBEEF);
         end
      end
      chk("drain_n", n_iss, 8);
      chk("drain_free", free_valid, 1);
      chk("drain_count", count, 0);

      // Write/CDB bypass in the write cycle
      do_reset();
      set_wr(2, 40, 0, 1, 32'h77, 9, 0, 0, 3);
      cdb_valid = 1; cdb_tag = 9; cdb_data = 32'h1234;
      cycle();
      idle();
      got = 0;
      for (int k = 0; k < 3; k++) begin
         cycle();
         if (issue_valid) begin
            got = 1;
            chk("byp_rs2", issue_rs2_val, 32'h1234);
         end
      end
      chk("byp_issued", got, 1);

      // Back-pressure hold, then back-to-back drain
      do_reset();
      issue_ready = 0;
      for (int i = 0; i < 3; i++) begin
         set_wr(i, 50 + i, 0, 1, i, 0, 1, i, 32'h100 + i);
         cycle();
      end
      idle();
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("hold_iv", issue_valid, 1);
         chk("hold_prd", issue_prd, 50);
         chk("hold_count", count, 2);
      end
      issue_ready = 1;
      cycle(); chk("b2b_prd1", issue_prd, 51); chk("b2b_iv1", issue_valid, 1);
      cycle(); chk("b2b_prd2", issue_prd, 52); chk("b2b_iv2", issue_valid, 1);
      cycle(); chk("b2b_iv3", issue_valid, 0);

      // Flush with a held issue and four waiting entries; concurrent write dropped
      do_reset();
      issue_ready = 0;
      set_wr(0, 1, 0, 1, 1, 0, 1, 1, 1);
      cycle();
      for (int i = 1; i < 5; i++) begin
         set_wr(i, i, 20, 0, 0, 0, 1, 0, i);
         cycle();
      end
      idle();
      chk("pre_flush_count", count, 4);
      chk("pre_flush_iv", issue_valid, 1);
      flush = 1;
      set_wr(5, 2, 0, 1, 0, 0, 1, 0, 0);
      cycle();
      idle();
      chk("flush_iv", issue_valid, 0);
      chk("flush_count", count, 0);
      chk("flush_free", free_addr, 0);
      issue_ready = 1;

      // Selection order: slot 3 written before slot 1
      do_reset();
      issue_ready = 0;
      set_wr(0, 60, 0, 1, 0, 0, 1, 0, 0); cycle();
      set_wr(3, 33, 0, 1, 0, 0, 1, 0, 0); cycle();
      set_wr(1, 11, 0, 1, 0, 0, 1, 0, 0); cycle();
      idle(); cycle();
      issue_ready = 1;
`ifdef RES_ST_OLDEST_FIRST_EN
      cycle(); chk("order_first", issue_prd, 33);
      cycle(); chk("order_second", issue_prd, 11);
`else
      cycle(); chk("order_first", issue_prd, 11);
      cycle(); chk("order_second", issue_prd, 33);
`endif

      // Randomized run against the model
      do_reset();
      for (int k = 0; k < 3000; k++) begin
         idle();
         issue_ready = ($urandom_range(0, 99) < 70);
         if ($urandom_range(0, 99) < 55) begin
            flist.delete();
            for (int i = 0; i < 8; i++) if (!m[i].v) flist.push_back(i);
            if (flist.size() > 0)
               set_wr(flist[$urandom_range(0, flist.size() - 1)], $urandom_range(0, 63),
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom,
                      $urandom_range(0, 7), $urandom_range(0, 1), $urandom, $urandom);
            else
               set_wr($urandom_range(0, 7), 0, 0, 1, 0, 0, 1, 0, 0);
         end
         if ($urandom_range(0, 99) < 40) begin
            cdb_valid = 1; cdb_tag = 6'($urandom_range(0, 7)); cdb_data = $urandom;
         end
         if ($urandom_range(0, 199) == 0) flush = 1;
         if ($urandom_range(0, 499) == 0) rst = 1;
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
